lif_array_scheduler: RTL and testbench

//  Time-multiplexes one shared leaky-integrate-and-fire update datapath across
//  N_NEURONS virtual neurons. Each timestep (start pulse) it walks neurons 0..N-1,

---
 rtl/lif_array_scheduler.sv | 147 ++++++++++++++
 tb/tb_lif_array_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_array_scheduler.sv
// Shared leaky-integrate-and-fire datapath time-multiplexed over N_NEURONS virtual neurons.
// Latency: start in cycle 0, done in cycle N+1; each spike adds one EMIT cycle plus stall cycles.
// Backpressure: spike events wait in EMIT with spk_valid/spk_id held until spk_ready; the walk freezes.
module lif_array_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int AW         = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          cur_we,
  input  logic [AW-1:0] cur_addr,
  input  logic [W-1:0]  cur_data,
  input  logic          thr_we,
  input  logic [W-1:0]  thr_data,
  output logic          spk_valid,
  input  logic          spk_ready,
  output logic [AW-1:0] spk_id,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_EMIT, S_DONE} fsm_t;

  fsm_t            state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;

  logic [W-1:0]    mem_q [N_NEURONS];
  logic [W-1:0]    cur_q [N_NEURONS];
  logic [N_NEURONS-1:0] spiked_q;
  logic [W-1:0]    thr_q;

  logic            last_idx;
  logic [W-1:0]    leak;
  logic [W:0]      sum;
  logic [W-1:0]    nxt;
  logic            spike;

  assign last_idx = (idx_q == AW'(N_NEURONS - 1));

  // Shared update datapath: leak (zeroed right after a spike), add current, saturate, compare.
  always_comb begin
    leak  = spiked_q[idx_q] ? '0 : (mem_q[idx_q] >> LEAK_SHIFT);
    sum   = {1'b0, cur_q[idx_q]} + {1'b0, leak};
    nxt   = sum[W] ? {W{1'b1}} : sum[W-1:0];
    spike = (nxt >= thr_q);
  end

  // FSM state and neuron index registers; reset aborts any timestep in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: walk neurons, detour through EMIT on a spike, finish through DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_UPDATE;
          idx_d   = '0;
        end
      end
      S_UPDATE: begin
        if (spike) begin
          state_d = S_EMIT;
        end else if (last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (spk_ready) begin
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            state_d = S_UPDATE;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state; spk_id is the frozen index while the event waits.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    spk_valid = (state_q == S_EMIT);
    spk_id    = (state_q == S_EMIT) ? idx_q : '0;
  end

  // Per-neuron storage: current writes any time, state/spiked written by the UPDATE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_q[i] <= '0;
        cur_q[i] <= '0;
      end
      spiked_q <= '0;
    end else begin
      // The datapath reads cur_q this cycle, so a same-cycle write lands for the next timestep.
      if (cur_we && (int'(cur_addr) < N_NEURONS)) begin
        cur_q[cur_addr] <= cur_data;
      end
      if (state_q == S_UPDATE) begin
        mem_q[idx_q]    <= nxt;
        spiked_q[idx_q] <= spike;
      end
    end
  end

  // Global threshold, only changeable between timesteps so a walk sees one value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= {1'b1, {(W-1){1'b0}}};
    end else if (thr_we && (state_q == S_IDLE)) begin
      thr_q <= thr_data;
    end
  end

  // Combinational state readback for debug.
  always_comb begin
    dbg_state = (int'(dbg_addr) < N_NEURONS) ? mem_q[dbg_addr] : '0;
  end

endmodule

// File: tb/tb_lif_array_scheduler.sv
// Self-checking bench for lif_array_scheduler: reference model feeds a spike-id scoreboard,
// done latency and stored state are compared after every timestep.
module tb_lif_array_scheduler;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [W-1:0]  cur_data;
  logic          thr_we;
  logic [W-1:0]  thr_data;
  logic          spk_valid;
  logic          spk_ready;
  logic [AW-1:0] spk_id;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_state;

  lif_array_scheduler #(.N_NEURONS(N), .W(W), .LEAK_SHIFT(1), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
    .thr_we(thr_we), .thr_data(thr_data),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_id(spk_id),
    .dbg_addr(dbg_addr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  int m_state [N];
  int m_cur   [N];
  bit m_spk   [N];
  int m_thr;
  int exp_q [$];
  int stall_left = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_cur[i]   = 0;
      m_spk[i]   = 1'b0;
    end
    m_thr = 128;
    exp_q.delete();
    stall_left = 0;
  endtask

  // Advances the model one timestep, pushes expected spike ids, returns spike count.
  task automatic model_step(output int nspk);
    int leak, nx;
    nspk = 0;
    for (int i = 0; i < N; i++) begin
      leak = m_spk[i] ? 0 : (m_state[i] >> 1);
      nx   = m_cur[i] + leak;
      if (nx > 255) nx = 255;
      m_state[i] = nx;
      m_spk[i]   = (nx >= m_thr);
      if (m_spk[i]) begin
        exp_q.push_back(i);
        nspk++;
      end
    end
  endtask

  // Downstream sink: decides spk_ready for the coming edge and scores handshakes.
  initial begin
    spk_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (spk_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          spk_ready = 1'b1;
          chk("spurious_spk_valid", spk_valid, 0);
        end else if (stall_left > 0) begin
          spk_ready = 1'b0;
          stall_left--;
          chk("spk_id_held", spk_id, exp_q[0]);
        end else begin
          spk_ready = 1'b1;
          chk("spk_id", spk_id, exp_q.pop_front());
        end
      end else begin
        spk_ready = 1'b1;
      end
    end
  end

  task automatic write_cur(input int a, input int d);
    @(negedge clk);
    cur_we = 1'b1; cur_addr = AW'(a); cur_data = W'(d);
    @(negedge clk);
    cur_we = 1'b0;
    m_cur[a] = d;
  endtask

  task automatic write_thr(input int d);
    @(negedge clk);
    thr_we = 1'b1; thr_data = W'(d);
    @(negedge clk);
    thr_we = 1'b0;
    m_thr = d;
  endtask

  task automatic read_dbg(input int a, output int v);
    dbg_addr = AW'(a);
    #1;
    v = int'(dbg_state);
  endtask

  // One timestep: start pulse, optional poke of start/thr_we while busy, latency and state checks.
  task automatic run_step(input int stalls, input bit poke);
    int nspk, exp_lat, cycle, v;
    @(negedge clk);
    start = 1'b1;
    stall_left = stalls;
    model_step(nspk);
    exp_lat = N + 1 + nspk + stalls;
    @(negedge clk);
    start = 1'b0;
    cycle = 1;
    while (cycle <= 100) begin
      if (done === 1'b1) break;
      if (cycle == 1) chk("busy_after_start", busy, 1);
      if (poke && cycle == 2) begin
        start = 1'b1; thr_we = 1'b1; thr_data = 8'd50;
      end else begin
        start = 1'b0; thr_we = 1'b0;
      end
      @(negedge clk);
      cycle++;
    end
    start = 1'b0; thr_we = 1'b0;
    chk("done_latency", cycle, exp_lat);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_clear", busy, 0);
    chk("events_drained", exp_q.size(), 0);
    for (int i = 0; i < N; i++) begin
      read_dbg(i, v);
      chk("state_vs_model", v, m_state[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, dcount;
    int t2_exp [4];
    int t4_exp [3];
    t2_exp = '{60, 90, 105, 60};
    t4_exp = '{200, 255, 200};

    rst_n = 1'b0; start = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = '0;
    thr_we = 1'b0; thr_data = '0; dbg_addr = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_spk_valid", spk_valid, 0);
    chk("rst_spk_id", spk_id, 0);
    for (int i = 0; i < N; i++) begin
      read_dbg(i, v);
      chk("rst_state", v, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Leak/integrate sequence with a post-spike reset on neuron 0
    write_thr(100);
    write_cur(0, 60);
    for (int k = 0; k < 4; k++) begin
      run_step(0, 1'b0);
      read_dbg(0, v);
      chk("t2_state0", v, t2_exp[k]);
    end

    // Stalled spike on neuron 2: id held three cycles, done delayed by three
    write_cur(0, 0);
    write_cur(2, 150);
    run_step(3, 1'b0);

    // Saturation without wrap at threshold 255
    write_thr(255);
    write_cur(2, 0);
    write_cur(1, 200);
    for (int k = 0; k < 3; k++) begin
      run_step(0, 1'b0);
      read_dbg(1, v);
      chk("t4_state1", v, t4_exp[k]);
    end

    // start and thr_we while busy are ignored
    write_cur(3, 60);
    run_step(0, 1'b1);
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("no_extra_timestep", dcount, 0);
    run_step(0, 1'b0);

    // Reset mid-UPDATE while neuron 2 is being updated
    write_cur(1, 0);
    write_cur(0, 10);
    write_cur(2, 20);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_spk_valid", spk_valid, 0);
    for (int i = 0; i < N; i++) begin
      read_dbg(i, v);
      chk("midrst_state", v, 0);
    end
    model_reset();
    dcount = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("midrst_no_done", dcount, 0);

    // Threshold returns to 128 after reset: 130 spikes, currents cleared elsewhere
    write_cur(0, 130);
    run_step(0, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
